mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-side signals around the refill/writeback arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_rvalid;
  logic          i_done;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_wready;
  logic [DW-1:0] d_rdata;
  logic          d_rvalid;
  logic          d_done;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    output i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
    input  i_rdata, i_rvalid, i_done, d_wready, d_rdata, d_rvalid, d_done,
           mem_req, mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master (I-cache / D-cache) line-burst arbiter onto a single-beat memory port.
// Define MEM_ARBITER_RR_EN for round-robin tie-breaking; otherwise D has fixed priority.
module mem_arbiter #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int unsigned BW         = $clog2(LINE_WORDS);
  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
  localparam logic [AW-1:0] BASE_MASK = ~AW'(LINE_BYTES - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        r_state;
  logic [BW-1:0] r_beat;
  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_base;

  logic          w_req_any;
  logic          w_grant_d;
  logic          w_burst;
  logic          w_ack;
  logic          w_rd_beat;
  logic [DW-1:0] w_rdata;

  assign w_req_any = bus.i_req | bus.d_req;

`ifdef MEM_ARBITER_RR_EN
  logic r_last_d;
  // On a tie, the side that did not win last time goes next.
  assign w_grant_d = bus.d_req & (~bus.i_req | ~r_last_d);
`else
  assign w_grant_d = bus.d_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_beat   <= '0;
      r_owner  <= 1'b0;
      r_we     <= 1'b0;
      r_base   <= '0;
`ifdef MEM_ARBITER_RR_EN
      r_last_d <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_state <= BURST;
            r_beat  <= '0;
            r_owner <= w_grant_d;
            r_we    <= w_grant_d & bus.d_we;
            r_base  <= (w_grant_d ? bus.d_addr : bus.i_addr) & BASE_MASK;
`ifdef MEM_ARBITER_RR_EN
            r_last_d <= w_grant_d;
`endif
          end
        end
        BURST: begin
          if (bus.mem_ack) begin
            r_beat <= r_beat + BW'(1);
            if (r_beat == LAST_BEAT) begin
              r_state <= FINISH;
            end
          end
        end
        FINISH:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_burst   = (r_state == BURST);
  assign w_ack     = bus.mem_ack & w_burst;
  assign w_rd_beat = w_ack & ~r_we;
  assign w_rdata   = bus.mem_rdata;

  // Memory side: beats only while bursting, addresses walk the line from its base.
  assign bus.mem_req   = w_burst;
  assign bus.mem_we    = w_burst & r_we;
  assign bus.mem_addr  = r_base + AW'({r_beat, 2'b00});
  assign bus.mem_wdata = bus.d_wdata;

  assign bus.i_rdata  = w_rdata;
  assign bus.d_rdata  = w_rdata;
  assign bus.i_rvalid = w_rd_beat & ~r_owner;
  assign bus.d_rvalid = w_rd_beat & r_owner;
  assign bus.d_wready = w_ack & r_owner & r_we;

  assign bus.i_done = (r_state == FINISH) & ~r_owner;
  assign bus.d_done = (r_state == FINISH) & r_owner;
  assign bus.busy   = (r_state != IDLE);
  assign bus.owner  = r_owner;
endmodule
